// File: rtl/mmio_ctrl.sv
// ---------------------------------------------------------------------------
// mmio_ctrl
//
// This is the memory-mapped I/O controller for the Riscv151 core. It decodes
// CPU load and store requests whose address has bit 31 set (the 0x8000_0000
// region). It owns the cycle and retired-instruction counters and sequences
// the on-chip UART.
//
// Load responses are registered. They come back one cycle after the request,
// which lines them up with the core's MEM/WB stage.
//
// Optional feature macro: MMIO_TX_FIFO_EN
//   defined   : transmit bytes are buffered in a TX_FIFO_DEPTH-entry FIFO.
//   undefined : stores to TX data drive the UART handshake combinationally.
//
// Parameters
//   TX_FIFO_DEPTH : TX FIFO entries; must be a power of two and at least 2.
//
// Ports
//   clk, rst        : clock and synchronous active-high reset
//   req_valid       : access request this cycle (already qualified by !stall)
//   req_we          : 1 = store, 0 = load
//   req_addr        : byte address (bit 31 and bits [7:0] are decoded)
//   req_wdata       : store data (only [7:0] is used)
//   instr_retire    : one instruction retired this cycle
//   mmio_hit        : combinational region hit, used by the core to mask dmem
//   rsp_valid       : registered load-response valid
//   rsp_rdata       : registered load data
//   uart_tx_data    : byte to the UART transmitter
//   uart_tx_valid   : TX handshake valid
//   uart_tx_ready   : TX handshake ready
//   uart_rx_data    : received byte
//   uart_rx_valid   : a received byte is available
//   uart_rx_ready   : combinational pop of the RX byte
//
// Register map (offset = req_addr[7:0])
//   0x00 R  status {29'b0, tx_overflow, rx_valid, tx_ready}; a read clears
//           tx_overflow
//   0x04 R  RX data; the byte is consumed when it is valid
//   0x08 W  TX data push; a push that cannot be taken sets tx_overflow
//   0x10 R  cycle counter
//   0x14 R  instruction counter
//   0x18 W  clear both counters
// ---------------------------------------------------------------------------
module mmio_ctrl #(
  parameter int TX_FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        instr_retire,
  output logic        mmio_hit,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready
);

  localparam logic [7:0] OFF_STATUS = 8'h00;
  localparam logic [7:0] OFF_RXDATA = 8'h04;
  localparam logic [7:0] OFF_TXDATA = 8'h08;
  localparam logic [7:0] OFF_CYCLE  = 8'h10;
  localparam logic [7:0] OFF_INSTR  = 8'h14;
  localparam logic [7:0] OFF_CLEAR  = 8'h18;

  // Reject depths the pointer arithmetic cannot handle.
  if (TX_FIFO_DEPTH < 2 || (TX_FIFO_DEPTH & (TX_FIFO_DEPTH - 1)) != 0) begin : g_depthCheck
    $error("mmio_ctrl: TX_FIFO_DEPTH must be a power of two and at least 2");
  end

  logic [7:0]  w_offset;
  logic        w_load;
  logic        w_store;
  logic        w_statusRead;
  logic        w_txPush;
  logic        w_txDrop;
  logic        w_txReady;
  logic        w_counterClear;
  logic [31:0] w_readData;
  logic        w_unusedBits;

  logic [31:0] r_cycleCounter;
  logic [31:0] r_instrCounter;
  logic        r_txOverflow;
  logic        r_rspValid;
  logic [31:0] r_rspRdata;

  // Address bits between 31 and 7 play no part in the decode.
  assign w_unusedBits = ^{req_addr[30:8], req_wdata[31:8]};

  assign w_offset       = req_addr[7:0];
  assign mmio_hit       = req_valid && req_addr[31];
  assign w_load         = mmio_hit && !req_we;
  assign w_store        = mmio_hit && req_we;
  assign w_statusRead   = w_load && (w_offset == OFF_STATUS);
  assign w_txPush       = w_store && (w_offset == OFF_TXDATA);
  assign w_counterClear = w_store && (w_offset == OFF_CLEAR);

  // The RX byte is popped in the request cycle itself. It is held low during
  // reset so that no byte is lost while the core is being reset.
  assign uart_rx_ready = !rst && w_load && (w_offset == OFF_RXDATA) && uart_rx_valid;

`ifdef MMIO_TX_FIFO_EN
  localparam int PTR_W = $clog2(TX_FIFO_DEPTH);

  logic [7:0]     r_txMem [TX_FIFO_DEPTH];
  logic [PTR_W:0] r_wrPtr;
  logic [PTR_W:0] r_rdPtr;
  logic [PTR_W:0] w_txCount;
  logic           w_txFull;
  logic           w_txEmpty;
  logic           w_txAccept;
  logic           w_txPop;

  // The pointers carry one extra wrap bit, so full and empty can be told
  // apart. Fullness is judged before any pop in the same cycle, which means a
  // push into a full FIFO is dropped even while an entry drains.
  assign w_txCount  = r_wrPtr - r_rdPtr;
  assign w_txFull   = (w_txCount == (PTR_W + 1)'(TX_FIFO_DEPTH));
  assign w_txEmpty  = (r_wrPtr == r_rdPtr);
  assign w_txAccept = w_txPush && !w_txFull;
  assign w_txDrop   = w_txPush && w_txFull;
  assign w_txPop    = !w_txEmpty && uart_tx_ready;
  assign w_txReady  = !w_txFull;

  assign uart_tx_valid = !w_txEmpty;
  assign uart_tx_data  = r_txMem[r_rdPtr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_txAccept) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_txPop)    r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

  // The storage needs no reset, because the pointers define which entries
  // are live.
  always_ff @(posedge clk) begin
    if (w_txAccept) r_txMem[r_wrPtr[PTR_W-1:0]] <= req_wdata[7:0];
  end
`else
  // Without a FIFO, the store goes straight to the UART. A store that meets a
  // busy transmitter is lost and is flagged as an overflow.
  assign uart_tx_valid = !rst && w_txPush;
  assign uart_tx_data  = req_wdata[7:0];
  assign w_txDrop      = w_txPush && !uart_tx_ready;
  assign w_txReady     = uart_tx_ready;
`endif

  // Read mux. Undefined offsets return 0, and an empty RX register returns 0.
  always_comb begin
    w_readData = '0;
    case (w_offset)
      OFF_STATUS: w_readData = {29'b0, r_txOverflow, uart_rx_valid, w_txReady};
      OFF_RXDATA: w_readData = uart_rx_valid ? {24'b0, uart_rx_data} : 32'b0;
      OFF_CYCLE:  w_readData = r_cycleCounter;
      OFF_INSTR:  w_readData = r_instrCounter;
      default:    w_readData = '0;
    endcase
  end

  // Counters. A clear store replaces that edge's increment, so both counters
  // read 0 in the following cycle.
  always_ff @(posedge clk) begin
    if (rst || w_counterClear) begin
      r_cycleCounter <= '0;
      r_instrCounter <= '0;
    end else begin
      r_cycleCounter <= r_cycleCounter + 32'd1;
      if (instr_retire) r_instrCounter <= r_instrCounter + 32'd1;
    end
  end

  // Sticky overflow. A drop in the same cycle as a status read wins, so the
  // bit stays set.
  always_ff @(posedge clk) begin
    if (rst)               r_txOverflow <= 1'b0;
    else if (w_txDrop)     r_txOverflow <= 1'b1;
    else if (w_statusRead) r_txOverflow <= 1'b0;
  end

  // One-cycle load response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rspValid <= 1'b0;
      r_rspRdata <= '0;
    end else begin
      r_rspValid <= w_load;
      if (w_load) r_rspRdata <= w_readData;
    end
  end

  assign rsp_valid = r_rspValid;
  assign rsp_rdata = r_rspRdata;

endmodule

// File: tb/tb_mmio_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mmio_ctrl
//
// Directed bench for mmio_ctrl. The expected values are worked out by hand.
// Inputs change on the falling edge, and every task starts and ends on a
// falling edge. Because of that, registered outputs seen after a task
// reflect the rising edge it spanned.
// ---------------------------------------------------------------------------
module tb_mmio_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        instr_retire;
  logic        mmio_hit;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic        uart_rx_ready;

  int checkCount = 0;
  int errorCount = 0;
  logic [31:0] rdData;

  mmio_ctrl #(.TX_FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .instr_retire(instr_retire),
    .mmio_hit(mmio_hit), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid),
    .uart_tx_ready(uart_tx_ready), .uart_rx_data(uart_rx_data),
    .uart_rx_valid(uart_rx_valid), .uart_rx_ready(uart_rx_ready)
  );

  always #5 clk = ~clk;

  // Counts one comparison and reports it if the values differ.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drives one request for one cycle. Called on a falling edge, and returns
  // on the next falling edge with the request removed.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  task automatic doRead(input logic [31:0] addr, output logic [31:0] data);
    applyStimulus(1'b0, addr, 32'h0);
    checkOutput("rsp_valid", {31'b0, rsp_valid}, 32'd1);
    data = rsp_rdata;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    instr_retire = 1'b0; uart_tx_ready = 1'b0; uart_rx_data = 8'h00; uart_rx_valid = 1'b0;

    // Reset: an RX read during reset must not pop the byte.
    repeat (3) @(negedge clk);
    uart_rx_valid = 1'b1; req_valid = 1'b1; req_addr = 32'h8000_0004;
    #1;
    checkOutput("rst_rx_ready", {31'b0, uart_rx_ready}, 32'd0);
    @(negedge clk);
    checkOutput("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("rst_tx_valid", {31'b0, uart_tx_valid}, 32'd0);
    req_valid = 1'b0; uart_rx_valid = 1'b0;
    rst = 1'b0;

    // After 10 idle edges the cycle counter reads exactly 10.
    repeat (10) @(negedge clk);
    doRead(32'h8000_0010, rdData);
    checkOutput("cycle_after_idle", rdData, 32'd10);
    doRead(32'h8000_0014, rdData);
    checkOutput("instr_idle", rdData, 32'd0);

    // Five retiring edges, then a counter clear.
    instr_retire = 1'b1;
    repeat (5) @(negedge clk);
    instr_retire = 1'b0;
    doRead(32'h8000_0014, rdData);
    checkOutput("instr_five", rdData, 32'd5);
    applyStimulus(1'b1, 32'h8000_0018, 32'h0);
    doRead(32'h8000_0010, rdData);
    checkOutput("cycle_cleared", rdData, 32'd0);
    doRead(32'h8000_0014, rdData);
    checkOutput("instr_cleared", rdData, 32'd0);

    // Wrap: preset the cycle counter to all ones, then read it twice back to back.
    force dut.r_cycleCounter = 32'hFFFF_FFFF;
    #1;
    release dut.r_cycleCounter;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8000_0010;
    @(negedge clk);
    checkOutput("cycle_max", rsp_rdata, 32'hFFFF_FFFF);
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("cycle_wrapped", rsp_rdata, 32'd0);

    // Non-MMIO load: no hit and no response. Undefined offset: response 0.
    req_valid = 1'b1; req_addr = 32'h0000_0010;
    #1;
    checkOutput("nonmmio_hit", {31'b0, mmio_hit}, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("nonmmio_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    doRead(32'h8000_0020, rdData);
    checkOutput("undef_offset", rdData, 32'd0);

    // RX read with a valid byte, then a repeat read with valid low.
    uart_rx_valid = 1'b1; uart_rx_data = 8'h5A;
    req_valid = 1'b1; req_addr = 32'h8000_0004;
    #1;
    checkOutput("rx_ready_pulse", {31'b0, uart_rx_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0; uart_rx_valid = 1'b0;
    #1;
    checkOutput("rx_ready_after", {31'b0, uart_rx_ready}, 32'd0);
    checkOutput("rx_data", rsp_rdata, 32'h0000_005A);
    req_valid = 1'b1; req_addr = 32'h8000_0004;
    #1;
    checkOutput("rx_ready_empty", {31'b0, uart_rx_ready}, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("rx_empty_data", rsp_rdata, 32'd0);

`ifdef MMIO_TX_FIFO_EN
    // Burst of 9 bytes into a depth-8 FIFO while the UART is stalled.
    uart_tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 32'h8000_0008, 32'h41 + i);
    doRead(32'h8000_0000, rdData);
    checkOutput("status_overflow", rdData, 32'b100);
    uart_tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checkOutput("drain_valid", {31'b0, uart_tx_valid}, 32'd1);
      checkOutput("drain_data", {24'b0, uart_tx_data}, 32'h41 + i);
      @(negedge clk);
    end
    checkOutput("drain_empty", {31'b0, uart_tx_valid}, 32'd0);
    uart_tx_ready = 1'b0;
    doRead(32'h8000_0000, rdData);
    checkOutput("status_cleared", rdData, 32'b001);

    // Push while full with a simultaneous pop: the push is dropped and the
    // FIFO count goes from 8 to 7.
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 32'h8000_0008, 32'h60 + i);
    uart_tx_ready = 1'b1;
    applyStimulus(1'b1, 32'h8000_0008, 32'h70);
    uart_tx_ready = 1'b0;
    doRead(32'h8000_0000, rdData);
    checkOutput("status_full_pop", rdData, 32'b101);
    uart_tx_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      checkOutput("fullpop_data", {24'b0, uart_tx_data}, 32'h60 + i);
      @(negedge clk);
    end
    checkOutput("fullpop_empty", {31'b0, uart_tx_valid}, 32'd0);

    // An empty FIFO does not bypass: the byte appears one cycle later.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h8000_0008; req_wdata = 32'h55;
    #1;
    checkOutput("nobypass_valid", {31'b0, uart_tx_valid}, 32'd0);
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0;
    checkOutput("nobypass_next", {24'b0, uart_tx_data}, 32'h55);
    @(negedge clk);
    checkOutput("nobypass_drained", {31'b0, uart_tx_valid}, 32'd0);

    // A reset in the middle of operation discards the queued bytes.
    uart_tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h8000_0008, 32'h90 + i);
    checkOutput("midrst_pending", {31'b0, uart_tx_valid}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_empty", {31'b0, uart_tx_valid}, 32'd0);
`else
    // Direct path: the write appears on the UART in the same cycle.
    uart_tx_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h8000_0008; req_wdata = 32'h33;
    #1;
    checkOutput("direct_valid", {31'b0, uart_tx_valid}, 32'd1);
    checkOutput("direct_data", {24'b0, uart_tx_data}, 32'h33);
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0;
    #1;
    checkOutput("direct_idle", {31'b0, uart_tx_valid}, 32'd0);
    uart_tx_ready = 1'b0;
    applyStimulus(1'b1, 32'h8000_0008, 32'h34);
    doRead(32'h8000_0000, rdData);
    checkOutput("direct_overflow", rdData, 32'b100);
    uart_tx_ready = 1'b1;
    doRead(32'h8000_0000, rdData);
    checkOutput("direct_cleared", rdData, 32'b001);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/mmio_ctrl.md
# mmio_ctrl

Memory-mapped I/O controller for the Riscv151 core. It sits beside the data memory port in the EX→MEM/WB boundary and decodes CPU load/store requests in the `0x8000_0000` region. It owns the cycle and instruction counters, and sequences the on-chip UART. It buffers transmit bytes in a FIFO and returns read data one cycle after the request, aligned with the core's MEM/WB stage.

## Interface
- `TX_FIFO_DEPTH`, default 8: TX FIFO entries; must be a power of two, ≥2.
- `clk` input 1: clock.
- `rst` input 1: reset; synchronous, active-high.
- `req_valid` input 1: access request this cycle. Already qualified by the core with `!stall`.
- `req_we` input 1: 1 = store, 0 = load.
- `req_addr` input 32: byte address from the ALU.
- `req_wdata` input 32: store data; only `[7:0]` is used.
- `instr_retire` input 1: one instruction retired this cycle.
- `mmio_hit` output 1: combinational; `req_valid && req_addr[31]`. The core uses it to suppress dmem write-enables.
- `rsp_valid` output 1: registered; the load response is in `rsp_rdata` this cycle.
- `rsp_rdata` output 32: registered load data.
- `uart_tx_data` output 8: byte to UART.
- `uart_tx_valid` output 1: UART TX handshake valid.
- `uart_tx_ready` input 1: UART TX handshake ready.
- `uart_rx_data` input 8: received byte.
- `uart_rx_valid` input 1: a received byte is available.
- `uart_rx_ready` output 1: combinational; pops the RX byte.

## Operation
- Decode uses `req_addr[31]` and `req_addr[7:0]`; the remaining bits are ignored.
  - Loads at undefined offsets return 0.
  - Stores at undefined offsets are ignored.
- Register map:
  - `0x00` read, status: `{29'b0, tx_overflow, rx_valid, tx_ready}`. `tx_ready` = TX FIFO not full. Reading status clears `tx_overflow`.
  - `0x04` read, RX data: `{24'b0, uart_rx_data}`. If `uart_rx_valid` is high, `uart_rx_ready` is asserted in the request cycle and the byte is consumed. If it is low, the read returns 0 and nothing is popped.
  - `0x08` write, TX data: pushes `req_wdata[7:0]`. A push to a full FIFO is dropped and sets sticky `tx_overflow`.
  - `0x10` read: `cycle_counter`.
  - `0x14` read: `instr_counter`.
  - `0x18` write: clears both counters.
- Counters:
  - 32-bit, wrap modulo 2^32.
  - `cycle_counter` increments every cycle.
  - `instr_counter` increments when `instr_retire` is high.
- TX drain:
  - `uart_tx_valid` = FIFO non-empty; `uart_tx_data` = FIFO head.
  - An entry pops on `uart_tx_valid && uart_tx_ready`.
  - Order is strictly FIFO; pointers wrap at `TX_FIFO_DEPTH`.
- Non-MMIO requests (`req_addr[31]==0`) have no effect and produce `rsp_valid=0`.

## Timing
- Reset values:
  - `rsp_valid` 0, `rsp_rdata` 0.
  - Counters 0; FIFO empty, so `uart_tx_valid` 0.
  - `tx_overflow` 0.
  - `uart_rx_ready` 0; it is combinational and gated by `!rst`.
- Reset applies mid-operation: FIFO contents are discarded with no partial drain.
- Load latency is exactly 1 cycle:
  - A request at edge N−1→N yields `rsp_valid=1` and data for cycle N+1.
  - Counter reads return the value held during the request cycle, before that edge's increment.
- A counter-clear store takes effect at the next edge: both counters read 0 in the following cycle. That edge's increment is suppressed.
- Full FIFO: fullness is evaluated before the same-cycle pop, so a push while full is dropped even if a pop occurs that edge.
- Empty FIFO: a push and the TX handshake in the same cycle do not bypass. The byte appears on `uart_tx_valid` the next cycle.
- Status `tx_ready` reflects FIFO state in the request cycle.
- If a status read clears `tx_overflow` in the same cycle as a dropped push, the new overflow wins and the bit stays set.
- At most one request per cycle; no backpressure to the core.

## Configuration
- `MMIO_TX_FIFO_EN` defined: TX FIFO of `TX_FIFO_DEPTH` entries as described.
- Not defined: no FIFO.
  - `uart_tx_valid` is combinational: `req_valid && req_we && offset==0x08`.
  - `uart_tx_data` = `req_wdata[7:0]`.
  - Status `tx_ready` = `uart_tx_ready`.
  - A write while `uart_tx_ready==0` is dropped and sets `tx_overflow`.

## Test plan
- Reset, then idle 10 cycles, then read `0x80000010`: `rsp_rdata`=10 (±request offset, checked exactly against the bench model); `0x80000014` = 0 with `instr_retire` low.
- Counter clear and wrap: preload by running with `instr_retire=1`, store to `0x80000018`, then read `0x80000014` → 0. Force `cycle_counter`=`0xFFFFFFFF`, advance 1 cycle → 0.
- TX burst with `MMIO_TX_FIFO_EN`, depth 8, `uart_tx_ready=0`: write bytes `0x41..0x49` (9 bytes). Expect:
  - Status = `0b100` (overflow set, `tx_ready` 0).
  - Releasing ready drains `0x41..0x48` in order.
  - Status after the clear reads `0b001`.
- RX: `uart_rx_valid=1`, data `0x5A`; read `0x80000004` → `uart_rx_ready` pulses 1 cycle, `rsp_rdata`=`0x0000005A`. A repeat read with valid low → 0, no pulse.
- Push while full with a simultaneous pop: the push is dropped, the FIFO count goes from 8 to 7, and `tx_overflow` is set.
- Without `MMIO_TX_FIFO_EN`: a write of `0x33` with `uart_tx_ready=1` drives `uart_tx_valid=1`, `uart_tx_data=0x33` in the same cycle.
